// File: rtl/osd_char_writer.sv
// -----------------------------------------------------------------------------
// osd_char_writer
//
// Command-driven producer for the OSD character buffer. Accepts ASCII text and
// cursor commands, translates ASCII into the 6-bit OSD charset, and keeps a
// cursor over the 16x8 character grid (address = row*16 + col). A CLEAR
// command fills the whole buffer with BLANK_CODE in a 128-cycle burst.
//
// Ports:
//   clk        VDP 21M clock
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  block can accept a command this cycle (IDLE and not in reset)
//   cmd_op     0=PUTC, 1=SETPOS, 2=CLEAR, 3=NEWLINE
//   cmd_data   ASCII byte (PUTC) or cursor address in [6:0] (SETPOS)
//   char_data  charset code to the OSD buffer
//   char_we    one-cycle write strobe to the OSD buffer
//   char_addr  buffer write address
//   cursor     current cursor address
//   busy       high while a CLEAR burst runs
// -----------------------------------------------------------------------------
module osd_char_writer #(
  parameter logic [5:0] BLANK_CODE = 6'h00,
  parameter bit         AUTO_CLEAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [5:0] char_data,
  output logic       char_we,
  output logic [6:0] char_addr,
  output logic [6:0] cursor,
  output logic       busy
);

  localparam logic [1:0] OP_PUTC    = 2'd0;
  localparam logic [1:0] OP_SETPOS  = 2'd1;
  localparam logic [1:0] OP_CLEAR   = 2'd2;
  localparam logic [1:0] OP_NEWLINE = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;

  // clr_cnt holds the next clear address to write; bit 7 set means all 128
  // addresses have been issued and the burst finishes this cycle.
  logic [7:0] clr_cnt;
  logic [7:0] clr_cnt_next;

  logic       we_next;
  logic [6:0] addr_next;
  logic [5:0] data_next;
  logic [6:0] cursor_next;
  logic [2:0] row_next;
  logic       accept;

  // ASCII to OSD charset: printable upper half maps directly, lowercase folds
  // onto uppercase, everything else becomes the blank glyph.
  function automatic logic [5:0] ascii_map(input logic [7:0] a);
    logic [7:0] t;
    if (a >= 8'h20 && a <= 8'h5F) begin
      t = a - 8'h20;
    end else if (a >= 8'h60 && a <= 8'h7F) begin
      t = a - 8'h40;
    end else begin
      t = {2'b00, BLANK_CODE};
    end
    return t[5:0];
  endfunction

  // cmd_ready is gated by rst directly so a command offered during reset is
  // never accepted, even though the state register may already read IDLE.
  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state == CLEAR);
  assign accept    = cmd_valid && cmd_ready;
  assign row_next  = cursor[6:4] + 3'd1;

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    we_next      = 1'b0;
    addr_next    = char_addr;
    data_next    = char_data;
    cursor_next  = cursor;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_PUTC: begin
              we_next     = 1'b1;
              addr_next   = cursor;
              data_next   = ascii_map(cmd_data);
              cursor_next = cursor + 7'd1;
            end
            OP_SETPOS: begin
              cursor_next = cmd_data[6:0];
            end
            OP_CLEAR: begin
              // Address 0 is written on the very next cycle, so the counter
              // starts at 1 to continue the burst from there.
              state_next   = CLEAR;
              we_next      = 1'b1;
              addr_next    = 7'd0;
              data_next    = BLANK_CODE;
              clr_cnt_next = 8'd1;
            end
            OP_NEWLINE: begin
              cursor_next = {row_next, 4'h0};
            end
            default: ;
          endcase
        end
      end

      CLEAR: begin
        if (clr_cnt[7]) begin
          state_next   = IDLE;
          clr_cnt_next = 8'd0;
          cursor_next  = 7'd0;
        end else begin
          we_next      = 1'b1;
          addr_next    = clr_cnt[6:0];
          data_next    = BLANK_CODE;
          clr_cnt_next = clr_cnt + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered control and output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      if (AUTO_CLEAR) begin
        state <= CLEAR;
      end else begin
        state <= IDLE;
      end
      clr_cnt   <= 8'd0;
      char_we   <= 1'b0;
      char_addr <= 7'd0;
      char_data <= 6'd0;
      cursor    <= 7'd0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      char_we   <= we_next;
      char_addr <= addr_next;
      char_data <= data_next;
      cursor    <= cursor_next;
    end
  end

endmodule

// File: tb/tb_osd_char_writer.sv
// -----------------------------------------------------------------------------
// tb_osd_char_writer
//
// Self-checking bench for osd_char_writer (AUTO_CLEAR=1, BLANK_CODE=0).
// A behavioural model (write queue, busy countdown, cursor arithmetic) is
// compared with the DUT every cycle; directed tests add literal expectations
// on the recorded write log.
// -----------------------------------------------------------------------------
module tb_osd_char_writer;

  localparam logic [5:0] BLANK = 6'h00;
  localparam bit         AUTO  = 1'b1;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [5:0] char_data;
  logic       char_we;
  logic [6:0] char_addr;
  logic [6:0] cursor;
  logic       busy;

  osd_char_writer #(.BLANK_CODE(BLANK), .AUTO_CLEAR(AUTO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .char_data (char_data),
    .char_we   (char_we),
    .char_addr (char_addr),
    .cursor    (cursor),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;

  // DUT write log
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int run_len = 0;
  int max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [6:0] a;
    logic [5:0] d;
  } wr_t;

  wr_t        mq[$];
  int         m_busy_left = 0;
  logic [6:0] m_cursor    = '0;
  logic [6:0] m_addr      = '0;
  logic [5:0] m_data      = '0;
  logic       m_we        = 1'b0;

  function automatic logic [5:0] osd_code(input logic [7:0] c);
    int v;
    v = int'(c);
    if (v >= 32 && v < 96)  return 6'(v - 32);
    if (v >= 96 && v < 128) return 6'(v - 64);
    return BLANK;
  endfunction

  task automatic queue_clear_burst();
    for (int i = 0; i < 128; i++) begin
      wr_t w;
      w.a = 7'(i);
      w.d = BLANK;
      mq.push_back(w);
    end
  endtask

  // Inputs change only 2 time units after a rising edge, so at the falling
  // edge they hold the values the next rising edge will sample.
  initial begin
    bit primed;
    bit acc;
    int r;
    wr_t w;
    primed = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (primed) begin
        chk("char_we",   32'(char_we),   32'(m_we));
        chk("char_addr", 32'(char_addr), 32'(m_addr));
        chk("char_data", 32'(char_data), 32'(m_data));
        chk("cursor",    32'(cursor),    32'(m_cursor));
        chk("busy",      32'(busy),      32'(m_busy_left > 0));
        chk("cmd_ready", 32'(cmd_ready), 32'((m_busy_left == 0) && !rst));
      end
      if (char_we === 1'b1) begin
        log_addr.push_back(int'(char_addr));
        log_data.push_back(int'(char_data));
        log_cyc.push_back(cyc);
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end

      if (rst) begin
        m_we = 1'b0; m_addr = '0; m_data = '0; m_cursor = '0;
        mq.delete();
        if (AUTO) begin
          m_busy_left = 129;
          queue_clear_burst();
        end else begin
          m_busy_left = 0;
        end
        primed = 1'b1;
      end else begin
        acc = cmd_valid && (m_busy_left == 0);
        if (m_busy_left > 0) begin
          m_busy_left--;
          if (m_busy_left == 0) m_cursor = '0;
        end
        if (acc) begin
          case (cmd_op)
            2'd0: begin
              w.a = m_cursor;
              w.d = osd_code(cmd_data);
              mq.push_back(w);
              m_cursor = 7'((int'(m_cursor) + 1) % 128);
            end
            2'd1: m_cursor = cmd_data[6:0];
            2'd2: begin
              queue_clear_burst();
              m_busy_left = 128;
            end
            default: begin
              r = int'(m_cursor) / 16;
              m_cursor = 7'(((r + 1) % 8) * 16);
            end
          endcase
        end
        if (mq.size() > 0) begin
          w = mq.pop_front();
          m_we = 1'b1; m_addr = w.a; m_data = w.d;
        end else begin
          m_we = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d, output int waited);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!acc && n < 400) begin
      acc = cmd_ready;
      @(posedge clk);
      #2;
      if (!acc) n++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(acc), 32'd1);
    waited = n;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < max_cycles) begin
      step(1);
      n++;
    end
    chk("idle_reached", 32'(cmd_ready), 32'd1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    max_run = 0;
  endtask

  task automatic check_burst(input string name, input int first);
    bit ok;
    ok = (log_addr.size() >= first + 128);
    for (int i = 0; i < 128 && ok; i++) begin
      if (log_addr[first + i] != i || log_data[first + i] != int'(BLANK)) ok = 1'b0;
      if (i > 0 && log_cyc[first + i] != log_cyc[first + i - 1] + 1) ok = 1'b0;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int w;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;

    // Power-on auto clear
    step(3);
    rst = 1'b0;
    clear_log();
    chk("busy_after_reset", 32'(busy), 32'd1);
    chk("ready_after_reset", 32'(cmd_ready), 32'd0);
    wait_idle(300);
    chk("autoclear_count", 32'(log_addr.size()), 32'd128);
    chk("autoclear_run", 32'(max_run), 32'd128);
    check_burst("autoclear_content", 0);
    chk("cursor_after_clear", 32'(cursor), 32'd0);
    chk("busy_after_clear", 32'(busy), 32'd0);

    // Back-to-back PUTC
    clear_log();
    send(2'd0, 8'h41, w);
    send(2'd0, 8'h62, w);
    send(2'd0, 8'h07, w);
    step(2);
    chk("putc_count", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("putc0_addr", 32'(log_addr[0]), 32'd0);
      chk("putc0_data", 32'(log_data[0]), 32'h21);
      chk("putc1_addr", 32'(log_addr[1]), 32'd1);
      chk("putc1_data", 32'(log_data[1]), 32'h22);
      chk("putc2_addr", 32'(log_addr[2]), 32'd2);
      chk("putc2_data", 32'(log_data[2]), 32'(BLANK));
      chk("putc_consecutive", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    end
    chk("putc_cursor", 32'(cursor), 32'd3);

    // Cursor wrap at 127
    clear_log();
    send(2'd1, 8'd127, w);
    send(2'd0, 8'h5A, w);
    send(2'd0, 8'h30, w);
    step(2);
    chk("wrap_count", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("wrap0_addr", 32'(log_addr[0]), 32'd127);
      chk("wrap0_data", 32'(log_data[0]), 32'h3A);
      chk("wrap1_addr", 32'(log_addr[1]), 32'd0);
      chk("wrap1_data", 32'(log_data[1]), 32'h10);
    end
    chk("wrap_cursor", 32'(cursor), 32'd1);

    // NEWLINE from last row wraps, from row 2 advances
    clear_log();
    send(2'd1, 8'h75, w);
    send(2'd3, 8'h00, w);
    step(1);
    chk("newline_wrap_cursor", 32'(cursor), 32'h00);
    send(2'd1, 8'h23, w);
    send(2'd3, 8'hFF, w);
    step(2);
    chk("newline_cursor", 32'(cursor), 32'h30);
    chk("newline_no_write", 32'(log_addr.size()), 32'd0);

    // CLEAR with a PUTC held off behind it
    send(2'd1, 8'h45, w);
    clear_log();
    send(2'd2, 8'h00, w);
    send(2'd0, 8'h21, w);
    chk("holdoff_cycles", 32'(w), 32'd128);
    step(2);
    chk("clear_putc_count", 32'(log_addr.size()), 32'd129);
    check_burst("clear_content", 0);
    if (log_addr.size() == 129) begin
      chk("post_clear_addr", 32'(log_addr[128]), 32'd0);
      chk("post_clear_data", 32'(log_data[128]), 32'h01);
      chk("post_clear_gap", 32'(log_cyc[128] - log_cyc[127]), 32'd2);
    end
    chk("post_clear_cursor", 32'(cursor), 32'd1);

    // Reset in the middle of a CLEAR burst restarts it from address 0
    send(2'd2, 8'h00, w);
    n = 0;
    while (!(char_we === 1'b1 && char_addr == 7'd60) && n < 300) begin
      step(1);
      n++;
    end
    chk("reached_addr60", 32'(char_addr), 32'd60);
    rst = 1'b1;
    @(negedge clk);
    #1;
    clear_log();
    step(2);
    rst = 1'b0;
    wait_idle(300);
    chk("rst_clear_count", 32'(log_addr.size()), 32'd128);
    if (log_addr.size() > 0) chk("rst_clear_first_addr", 32'(log_addr[0]), 32'd0);
    chk("rst_clear_run", 32'(max_run), 32'd128);
    check_burst("rst_clear_content", 0);
    step(3);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/osd_char_writer.md
Name: osd_char_writer

Overview:
- Command-driven producer for the OSD character buffer, driving its char_data/char_we/char_addr write port.
- Accepts ASCII text and cursor commands from the control side (MSX I/O decode or a boot message sequencer), maps ASCII to the 6-bit OSD charset and tracks a cursor over the 16x8 grid.
- Performs full-screen clears as a 128-cycle burst.

Parameters:
- BLANK_CODE, 6'h00, charset code written by CLEAR and substituted for unmappable ASCII.
- AUTO_CLEAR, 1, when 1 the block runs a CLEAR burst immediately after reset.

Ports:
- clk  input  1  VDP 21M clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_op  input  2  0=PUTC, 1=SETPOS, 2=CLEAR, 3=NEWLINE
- cmd_data  input  8  ASCII byte (PUTC) or cursor address in [6:0] (SETPOS); ignored for other ops
- char_data  output  6  charset code to OSD buffer
- char_we  output  1  one-cycle write strobe to OSD buffer
- char_addr  output  7  buffer address, row*16+col
- cursor  output  7  current cursor address
- busy  output  1  high while a CLEAR burst runs

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous and active-high.
- Reset values: char_we=0, char_addr=0, char_data=0, cursor=0, cmd_ready=0.
  - AUTO_CLEAR=1: busy=1 and state=CLEAR with clear counter=0 on the first cycle after reset.
  - AUTO_CLEAR=0: busy=0 and state=IDLE.
- States: IDLE and CLEAR.
  - cmd_ready = (state==IDLE) and not in reset. busy = (state==CLEAR).
  - Accept = cmd_valid && cmd_ready. All outputs are registered.
- PUTC, accepted in cycle N:
  - In cycle N+1: char_we=1, char_addr=cursor value at N, char_data=map(cmd_data), cursor=cursor+1 mod 128 (127 wraps to 0).
  - State stays IDLE, so back-to-back PUTC sustains one write per cycle.
- SETPOS: cursor=cmd_data[6:0] at N+1; char_we=0.
- NEWLINE: cursor={(cursor[6:4]+1) mod 8, 4'h0} at N+1; row 7 wraps to row 0. No write.
- CLEAR, accepted at N:
  - state=CLEAR from N+1.
  - Cycles N+1..N+128: char_we=1, char_addr=0..127 ascending, char_data=BLANK_CODE.
  - Cycle N+129: char_we=0, state=IDLE, cursor=0.
  - cmd_ready=0 throughout; commands offered meanwhile are held off, not dropped.
- char_we is 0 in any cycle without a write. char_addr/char_data hold their last values when char_we=0.
- ASCII map (8-bit in, 6-bit out):
  - 0x20-0x5F -> ascii-0x20.
  - 0x60-0x7F -> ascii-0x40 (folds lowercase to uppercase).
  - 0x00-0x1F and 0x80-0xFF -> BLANK_CODE.
- Reset mid-CLEAR: abort. If AUTO_CLEAR=1 the burst restarts at address 0; otherwise the block returns to IDLE with a partially cleared buffer.
- Reset while cmd_valid is high: the command is not accepted.
- cmd_op/cmd_data are sampled only on accept; changes while cmd_ready=0 have no effect.

Test Plan:
- Reset with AUTO_CLEAR=1, cmd_valid=0:
  - char_we high for exactly 128 consecutive cycles, addresses 0..127, data 6'h00.
  - Then cmd_ready=1, cursor=0, busy=0.
- Idle, PUTC 'A'(0x41),'b'(0x62),0x07 back-to-back:
  - Writes (addr,data)=(0,0x21),(1,0x22),(2,BLANK_CODE) on three consecutive cycles.
  - cursor=3 afterwards.
- SETPOS 127 then PUTC 'Z'(0x5A), PUTC '0'(0x30):
  - Writes (127,0x3A) then (0,0x10); cursor=1.
- SETPOS 0x75 (row 7, col 5) then NEWLINE:
  - cursor=0x00, no char_we pulse.
  - SETPOS 0x23 then NEWLINE -> cursor=0x30.
- CLEAR accepted, cmd_valid held high with PUTC '!'(0x21) from the next cycle:
  - cmd_ready=0 for 128 cycles, all writes BLANK_CODE.
  - The first post-clear write is (0,0x01).
- rst asserted at clear address 60, AUTO_CLEAR=1:
  - The next char_we after release is at addr 0, followed by a full 128-write burst.
